prbs35_checker: RTL and testbench
=================================

# prbs35_checker

Receive-side companion to the degree-35 PRBS source: consumes the serial PRBS bit stream, self-synchronises a local 35-bit reference register to it, then flags and counts bit errors. Sits at the far end of a link or loopback under test and gives BIST/BER status to the control block. Stream recurrence: b[n] = b[n-1] XOR b[n-35].

## Interface
- LOCK_CNT, 64: consecutive correct predictions needed to declare lock (1..2^16-1)
- WIN_LEN, 256: locked-mode monitoring window length in bits (≥ LOSS_THR)
- LOSS_THR, 16: errors within one window that force loss of lock (≥1)
- ERR_W, 32: width of error and bit counters
- Clk_CI  in  1  clock; all logic on rising edge
- Rst_RBI  in  1  reset; synchronous, active-low
- Valid_SI  in  1  Data_DI carries a stream bit this cycle
- Data_DI  in  1  received PRBS bit
- Clr_SI  in  1  clear ErrCnt_DO and BitCnt_DO (lock state untouched)
- Locked_SO  out  1  checker synchronised
- BitErr_SO  out  1  one-cycle pulse: last checked bit mismatched
- ErrCnt_DO  out  ERR_W  saturating count of mismatches while locked
- BitCnt_DO  out  ERR_W  saturating count of bits checked while locked

## Operation
- Reference register R[34:0], R[0] = most recent bit. Prediction P = R[0] XOR R[34]. Nothing changes on cycles with Valid_SI=0.
- HUNT (reset state): every valid bit shifts Data_DI into R. Fill counter counts first 35 valid bits; no comparisons until full. Once full, each valid bit compares Data_DI to P: match with R ≠ 0 increments match counter; mismatch, or R == 0, clears it. Match counter reaching LOCK_CNT → LOCKED.
- All-zero stream never locks (R == 0 guard).
- LOCKED: each valid bit: err = Data_DI XOR P; BitErr_SO <= err; BitCnt_DO += 1; ErrCnt_DO += err; window error counter += err. R shift input per Configuration.
- Window: bit counter counts WIN_LEN valid bits then clears itself and window error counter. Window error counter reaching LOSS_THR → HUNT with R fill counter, match counter, window counters cleared (R contents irrelevant, refilled).
- Both ErrCnt_DO and BitCnt_DO saturate at 2^ERR_W-1; they hold across loss of lock and only count in LOCKED.
- Clr_SI has priority over increments in the same cycle (counters become 0, that bit not counted); BitErr_SO still reports the bit.
- Reset mid-operation: everything returns to reset values at next edge, regardless of Valid_SI.

## Timing
- Reset values: Locked_SO=0, BitErr_SO=0, ErrCnt_DO=0, BitCnt_DO=0, state HUNT, R=0, all internal counters 0.
- All outputs registered. BitErr_SO, ErrCnt_DO, BitCnt_DO update the cycle after the valid bit is sampled; BitErr_SO low otherwise.
- Lock latency: Locked_SO rises the cycle after the (35+LOCK_CNT)-th consecutive valid error-free bit (99th with defaults). The LOCK_CNT-th match bit itself is not counted in ErrCnt/BitCnt.
- Loss of lock: Locked_SO falls the cycle after the bit that brings the window count to LOSS_THR; that bit is counted.
- Valid gaps of any length allowed; behaviour depends only on the valid-bit sequence.

## Configuration
- PRBS35_CHK_FLYWHEEL_EN defined: in LOCKED, R shifts in P (flywheel); one flipped input bit yields exactly one BitErr_SO pulse.
- Undefined: in LOCKED, R shifts in Data_DI (self-synchronising); one flipped bit yields three pulses, at bits n, n+1, n+35. HUNT behaviour identical either way.

## Test plan
- Clean PRBS from seed 35'h1, Valid_SI=1 continuously -> Locked_SO=1 one cycle after bit 99; after 1000 further bits BitCnt_DO=1000, ErrCnt_DO=0, BitErr_SO never asserted.
- Locked, flip one bit -> FLYWHEEL_EN: ErrCnt_DO=1, one pulse; undefined: ErrCnt_DO=3, pulses at flipped bit, +1, +35.
- Locked, inject 16 errors within 256 bits -> Locked_SO=0 cycle after 16th error; relock after 99 further clean bits; ErrCnt_DO retains 16 (FLYWHEEL_EN).
- All-zero input for 500 bits -> Locked_SO stays 0; random input -> no lock.
- Clr_SI asserted coincident with an error bit -> ErrCnt_DO=0, BitCnt_DO=0, BitErr_SO=1; Valid_SI toggling 1/0 gives identical lock bit index to continuous case.
- Rst_RBI low one cycle while locked with ErrCnt_DO=5 -> next cycle all outputs 0, state HUNT; ERR_W=4 with 20 errors -> ErrCnt_DO holds 15.

Source files
------------

// File: rtl/prbs35_checker_if.sv
// rtl/prbs35_checker_if.sv - stream, clear and status bundle between the PRBS-35 checker and its user
interface prbs35_checker_if #(
  parameter int ERR_W = 32
);
  logic             Valid_SI;
  logic             Data_DI;
  logic             Clr_SI;
  logic             Locked_SO;
  logic             BitErr_SO;
  logic [ERR_W-1:0] ErrCnt_DO;
  logic [ERR_W-1:0] BitCnt_DO;

  modport master (
    output Valid_SI, Data_DI, Clr_SI,
    input  Locked_SO, BitErr_SO, ErrCnt_DO, BitCnt_DO
  );

  modport slave (
    input  Valid_SI, Data_DI, Clr_SI,
    output Locked_SO, BitErr_SO, ErrCnt_DO, BitCnt_DO
  );
endinterface

// File: rtl/prbs35_checker.sv
// rtl/prbs35_checker.sv - PRBS-35 receive checker with self-sync, lock/loss tracking and BER counters; optional macro PRBS35_CHK_FLYWHEEL_EN
module prbs35_checker #(
  parameter int LOCK_CNT = 64,
  parameter int WIN_LEN  = 256,
  parameter int LOSS_THR = 16,
  parameter int ERR_W    = 32
) (
  input  logic            Clk_CI,
  input  logic            Rst_RBI,
  prbs35_checker_if.slave bus
);
  localparam logic [0:0]      S_HUNT    = 1'b0;
  localparam logic [0:0]      S_LOCKED  = 1'b1;
  localparam int              WB_W      = $clog2(WIN_LEN + 1);
  localparam int              WE_W      = $clog2(LOSS_THR + 1);
  localparam logic [5:0]      FILL_LEN  = 6'd35;
  localparam logic [15:0]     LOCK_LAST = 16'(LOCK_CNT - 1);
  localparam logic [WB_W-1:0] WIN_LAST  = WB_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0] LOSS_LAST = WE_W'(LOSS_THR - 1);

  logic [0:0]      r_state;
  logic [34:0]     r_ref;
  logic [5:0]      r_fill;
  logic [15:0]     r_match;
  logic [WB_W-1:0] r_win_bits;
  logic [WE_W-1:0] r_win_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_bit_cnt;
  logic            r_bit_err;

  logic w_pred;
  logic w_err;
  logic w_ref_full;
  logic w_ref_zero;
  logic w_locked_bit;
  logic w_loss;
  logic w_lock_in;
  logic w_shift_in;

  assign w_pred       = r_ref[0] ^ r_ref[34];
  assign w_err        = bus.Data_DI ^ w_pred;
  assign w_ref_full   = (r_fill == FILL_LEN);
  assign w_ref_zero   = (r_ref == '0);
  assign w_locked_bit = bus.Valid_SI && (r_state == S_LOCKED);
  assign w_loss       = w_err && (r_win_err == LOSS_LAST);

`ifdef PRBS35_CHK_FLYWHEEL_EN
  // Flywheel: once locked the reference free-runs on its own prediction.
  assign w_lock_in = w_pred;
`else
  // Self-synchronising: the reference always follows the received stream.
  assign w_lock_in = bus.Data_DI;
`endif

  assign w_shift_in = (r_state == S_LOCKED) ? w_lock_in : bus.Data_DI;

  // Reference register: shift one bit per valid input, newest bit in r_ref[0].
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_ref <= '0;
    end else if (bus.Valid_SI) begin
      r_ref <= {r_ref[33:0], w_shift_in};
    end
  end

  // Hunt/lock state machine with fill, match and monitoring-window counters.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_state    <= S_HUNT;
      r_fill     <= '0;
      r_match    <= '0;
      r_win_bits <= '0;
      r_win_err  <= '0;
    end else if (bus.Valid_SI) begin
      if (r_state == S_HUNT) begin
        if (!w_ref_full) begin
          r_fill <= r_fill + 6'd1;
        end else if (!w_err && !w_ref_zero) begin
          if (r_match == LOCK_LAST) begin
            r_state    <= S_LOCKED;
            r_match    <= '0;
            r_win_bits <= '0;
            r_win_err  <= '0;
          end else begin
            r_match <= r_match + 16'd1;
          end
        end else begin
          r_match <= '0;
        end
      end else begin
        if (w_loss) begin
          // Too many errors in this window: drop lock and refill the reference.
          r_state    <= S_HUNT;
          r_fill     <= '0;
          r_match    <= '0;
          r_win_bits <= '0;
          r_win_err  <= '0;
        end else if (r_win_bits == WIN_LAST) begin
          r_win_bits <= '0;
          r_win_err  <= '0;
        end else begin
          r_win_bits <= r_win_bits + 1'b1;
          r_win_err  <= r_win_err + WE_W'(w_err);
        end
      end
    end
  end

  // Status outputs: error pulse plus saturating error/bit counters; clear wins over counting.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_bit_err <= 1'b0;
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_bit_err <= w_locked_bit && w_err;
      if (bus.Clr_SI) begin
        r_err_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (w_locked_bit) begin
        if (r_bit_cnt != '1) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_err && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.Locked_SO = (r_state == S_LOCKED);
  assign bus.BitErr_SO = r_bit_err;
  assign bus.ErrCnt_DO = r_err_cnt;
  assign bus.BitCnt_DO = r_bit_cnt;
endmodule

// File: tb/tb_prbs35_checker.sv
// tb/tb_prbs35_checker.sv - self-checking bench for prbs35_checker (scoreboard plus table of error-injection records)
module tb_prbs35_checker;
  localparam int LOCK_CNT = 64;
  localparam int WIN_LEN  = 256;
  localparam int LOSS_THR = 16;
`ifdef PRBS35_CHK_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif
  localparam int EPF      = FLY ? 1 : 3;
  localparam int LOSS_NF  = FLY ? 16 : 8;
  localparam int LOSS_OFF = FLY ? 45 : 22;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  prbs35_checker_if #(.ERR_W(32)) bus ();
  prbs35_checker_if #(.ERR_W(4))  sbus ();

  assign sbus.Valid_SI = bus.Valid_SI;
  assign sbus.Data_DI  = bus.Data_DI;
  assign sbus.Clr_SI   = bus.Clr_SI;

  prbs35_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .ERR_W(32)) dut (
    .Clk_CI(clk), .Rst_RBI(rstn), .bus(bus)
  );
  prbs35_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(200), .ERR_W(4)) sdut (
    .Clk_CI(clk), .Rst_RBI(rstn), .bus(sbus)
  );

  typedef struct {
    logic        lock;
    logic        berr;
    logic [31:0] err;
    logic [31:0] bits;
  } exp_t;

  typedef struct {
    int gap;
    int nflip;
    int spacing;
    bit gappy;
    int tail;
    int exp_err;
    int exp_bits;
  } vec_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;
  logic [34:0] gen;
  bit fh[0:16383];
  int bidx = 0;
  bit m_locked, m_bad;
  int m_run, m_wpos, m_werr;
  logic [31:0] m_err, m_bits;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit gen_next();
    bit nb;
    nb = gen[0] ^ gen[34];
    gen = {gen[33:0], nb};
    return nb;
  endfunction

  function automatic bit fh_at(input int i);
    return (i < 0) ? 1'b0 : fh[i];
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_bad = 0; m_run = 0; m_wpos = 0; m_werr = 0; m_err = 0; m_bits = 0;
  endfunction

  // mode 0: PRBS stream (optionally flipped), 1: all zero, 2: random
  task automatic step(input bit v, input int mode, input bit flip, input bit clr);
    exp_t e;
    bit d, eb;
    d = 1'b0;
    if (v) begin
      case (mode)
        0:       d = gen_next() ^ flip;
        1:       d = 1'b0;
        default: d = 1'($urandom);
      endcase
    end
    eb = 1'b0;
    if (v && m_locked) eb = FLY ? flip : (flip ^ fh_at(bidx - 1) ^ fh_at(bidx - 35));
    if (clr) begin
      m_err = 0; m_bits = 0;
    end else if (v && m_locked) begin
      m_bits++;
      if (eb) m_err++;
    end
    e.berr = eb;
    if (v) begin
      fh[bidx] = flip;
      bidx++;
      if (!m_locked) begin
        if (m_bad || flip) m_run = 0;
        else m_run++;
        if (m_run == 35 + LOCK_CNT) begin
          m_locked = 1; m_wpos = 0; m_werr = 0;
        end
      end else if (eb && m_werr == LOSS_THR - 1) begin
        m_locked = 0; m_run = 0;
      end else if (m_wpos == WIN_LEN - 1) begin
        m_wpos = 0; m_werr = 0;
      end else begin
        m_wpos++; m_werr += int'(eb);
      end
    end
    e.lock = m_locked; e.err = m_err; e.bits = m_bits;
    sb.push_back(e);
    bus.Valid_SI = v; bus.Data_DI = d; bus.Clr_SI = clr;
    @(posedge clk); #1;
    bus.Valid_SI = 1'b0; bus.Clr_SI = 1'b0;
    e = sb.pop_front();
    check("sb_locked", 32'(bus.Locked_SO), 32'(e.lock));
    check("sb_biterr", 32'(bus.BitErr_SO), 32'(e.berr));
    check("sb_errcnt", bus.ErrCnt_DO, e.err);
    check("sb_bitcnt", bus.BitCnt_DO, e.bits);
    if (bus.BitErr_SO) n_pulse++;
  endtask

  task automatic send(input bit flip, input bit gappy);
    step(1'b1, 0, flip, 1'b0);
    if (gappy) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0; bus.Valid_SI = 1'b1; bus.Data_DI = 1'($urandom); bus.Clr_SI = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; bus.Valid_SI = 1'b0;
    model_reset();
  endtask

  task automatic align_window();
    for (int i = 0; i < 300 && m_wpos != 0; i++) send(1'b0, 1'b0);
  endtask

  task automatic lock_index(input bit gappy, output int idx);
    idx = 0;
    for (int i = 1; i <= 150; i++) begin
      step(1'b1, 0, 1'b0, 1'b0);
      if (bus.Locked_SO) begin
        idx = i;
        if (i == 98 + 1) check("lock_bitcnt", bus.BitCnt_DO, 32'd0);
        break;
      end
      if (i == 98) check("prelock", 32'(bus.Locked_SO), 32'd0);
      if (gappy) step(1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    bus.Valid_SI = 1'b0; bus.Data_DI = 1'b0; bus.Clr_SI = 1'b0;
    gen = 35'h1;
    model_reset();
    tbl[0] = '{gap: 10, nflip: 1, spacing: 0,  gappy: 1'b0, tail: 40, exp_err: 0, exp_bits: 0};
    tbl[1] = '{gap: 20, nflip: 2, spacing: 50, gappy: 1'b0, tail: 40, exp_err: 0, exp_bits: 0};
    tbl[2] = '{gap: 5,  nflip: 1, spacing: 0,  gappy: 1'b1, tail: 40, exp_err: 0, exp_bits: 0};
    tbl[3] = '{gap: 30, nflip: 3, spacing: 40, gappy: 1'b1, tail: 40, exp_err: 0, exp_bits: 0};
    for (int i = 0; i < 4; i++) begin
      tbl[i].exp_err  = tbl[i].nflip * EPF;
      tbl[i].exp_bits = tbl[i].gap + (tbl[i].nflip - 1) * tbl[i].spacing + 1 + tbl[i].tail;
    end

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_locked", 32'(bus.Locked_SO), 32'd0);
    check("rst_biterr", 32'(bus.BitErr_SO), 32'd0);
    check("rst_errcnt", bus.ErrCnt_DO, 32'd0);
    check("rst_bitcnt", bus.BitCnt_DO, 32'd0);

    m_bad = 1;
    for (int i = 0; i < 500; i++) step(1'b1, 1, 1'b0, 1'b0);
    check("zero_nolock", 32'(bus.Locked_SO), 32'd0);
    apply_reset();
    m_bad = 1;
    for (int i = 0; i < 500; i++) step(1'b1, 2, 1'b0, 1'b0);
    check("rand_nolock", 32'(bus.Locked_SO), 32'd0);

    apply_reset(); gen = 35'h1;
    lock_index(1'b1, idx);
    check("lock_idx_gappy", idx, 32'd99);
    apply_reset(); gen = 35'h1;
    lock_index(1'b0, idx);
    check("lock_idx_cont", idx, 32'd99);

    n_pulse = 0;
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
    check("clean_bitcnt", bus.BitCnt_DO, 32'd1000);
    check("clean_errcnt", bus.ErrCnt_DO, 32'd0);
    check("clean_pulses", n_pulse, 32'd0);

    for (int r = 0; r < 4; r++) begin
      align_window();
      step(1'b0, 0, 1'b0, 1'b1);
      n_pulse = 0;
      for (int k = 0; k < tbl[r].gap; k++) send(1'b0, tbl[r].gappy);
      for (int f = 0; f < tbl[r].nflip; f++) begin
        send(1'b1, tbl[r].gappy);
        if (f < tbl[r].nflip - 1)
          for (int k = 1; k < tbl[r].spacing; k++) send(1'b0, tbl[r].gappy);
      end
      for (int k = 0; k < tbl[r].tail; k++) send(1'b0, tbl[r].gappy);
      check("tbl_errcnt", bus.ErrCnt_DO, tbl[r].exp_err);
      check("tbl_bitcnt", bus.BitCnt_DO, tbl[r].exp_bits);
      check("tbl_pulses", n_pulse, tbl[r].exp_err);
      check("tbl_locked", 32'(bus.Locked_SO), 32'd1);
    end

    align_window();
    for (int k = 0; k < 5; k++) send(1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 1'b1);
    check("clr_biterr", 32'(bus.BitErr_SO), 32'd1);
    check("clr_errcnt", bus.ErrCnt_DO, 32'd0);
    check("clr_bitcnt", bus.BitCnt_DO, 32'd0);
    for (int k = 0; k < 40; k++) send(1'b0, 1'b0);

    step(1'b0, 0, 1'b0, 1'b1);
    for (int f = 0; f < 20; f++) begin
      send(1'b1, 1'b0);
      for (int k = 1; k < 80; k++) send(1'b0, 1'b0);
    end
    check("sat_small_err", 32'(sbus.ErrCnt_DO), 32'd15);
    check("sat_small_bits", 32'(sbus.BitCnt_DO), 32'd15);
    check("sat_main_err", bus.ErrCnt_DO, 32'(20 * EPF));

    step(1'b0, 0, 1'b0, 1'b1);
    align_window();
    for (int off = 0; off <= LOSS_OFF; off++) begin
      if (off == LOSS_OFF) check("loss_prelocked", 32'(bus.Locked_SO), 32'd1);
      send((off % 3 == 0) && (off / 3 < LOSS_NF), 1'b0);
    end
    check("loss_locked", 32'(bus.Locked_SO), 32'd0);
    check("loss_errcnt", bus.ErrCnt_DO, 32'd16);
    for (int k = 0; k < 98; k++) send(1'b0, 1'b0);
    check("relock_pre", 32'(bus.Locked_SO), 32'd0);
    send(1'b0, 1'b0);
    check("relock", 32'(bus.Locked_SO), 32'd1);
    check("relock_errcnt", bus.ErrCnt_DO, 32'd16);

    step(1'b0, 0, 1'b0, 1'b1);
    for (int off = 0; off <= (FLY ? 200 : 110); off++) begin
      if (FLY) send((off % 40 == 0) && (off <= 160), 1'b0);
      else     send((off == 0) || (off == 35) || (off == 70), 1'b0);
    end
    check("five_errcnt", bus.ErrCnt_DO, 32'd5);
    check("five_locked", 32'(bus.Locked_SO), 32'd1);
    apply_reset();
    check("mid_rst_locked", 32'(bus.Locked_SO), 32'd0);
    check("mid_rst_biterr", 32'(bus.BitErr_SO), 32'd0);
    check("mid_rst_errcnt", bus.ErrCnt_DO, 32'd0);
    check("mid_rst_bitcnt", bus.BitCnt_DO, 32'd0);
    for (int k = 0; k < 98; k++) send(1'b0, 1'b0);
    check("post_rst_hunt", 32'(bus.Locked_SO), 32'd0);
    send(1'b0, 1'b0);
    check("post_rst_lock", 32'(bus.Locked_SO), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
